dat_mem_arb: RTL

//  Two-requester arbiter sharing the single-port 256x8 data memory.

---
 rtl/dat_mem_arb.sv | 134 +++++++++++++
 1 files changed

// File: rtl/dat_mem_arb.sv
// Round-robin arbiter giving two requesters one access per cycle to a single-port memory, with bounded lock ownership.
// Grant is combinational (same cycle); read data is registered, one cycle after grant. A losing requester holds its inputs until granted.
module dat_mem_arb #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int LOCK_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdat,
  input  logic          r0_lock,
  output logic          r0_gnt,
  output logic          r0_rvld,
  output logic [DW-1:0] r0_rdat,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdat,
  input  logic          r1_lock,
  output logic          r1_gnt,
  output logic          r1_rvld,
  output logic [DW-1:0] r1_rdat,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr_en,
  output logic [DW-1:0] mem_dat_in,
  input  logic [DW-1:0] mem_dat_out
);

  localparam logic [4:0] LOCK_LIM = 5'(LOCK_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        last;
  logic        last_nxt;
  logic [3:0]  lock_cnt;
  logic [3:0]  lock_cnt_nxt;
  logic [3:0]  base_cnt;
  logic [4:0]  cnt_inc;
  logic        gnt0;
  logic        gnt1;
  logic        sel_lock;
  logic        other_req;
  logic        rvld0_q;
  logic        rvld1_q;

  // An owner keeps the port while it requests; otherwise fall back to round-robin.
  always_comb begin : grant_logic
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (state == OWN0 && r0_req) begin
        gnt0 = 1'b1;
      end else if (state == OWN1 && r1_req) begin
        gnt1 = 1'b1;
      end else if (r0_req && r1_req) begin
        gnt0 = last;
        gnt1 = !last;
      end else begin
        gnt0 = r0_req;
        gnt1 = r1_req;
      end
    end
  end

  always_comb begin : mem_mux
    mem_addr   = '0;
    mem_wr_en  = 1'b0;
    mem_dat_in = '0;
    if (gnt0) begin
      mem_addr   = r0_addr;
      mem_wr_en  = r0_we;
      mem_dat_in = r0_wdat;
    end else if (gnt1) begin
      mem_addr   = r1_addr;
      mem_wr_en  = r1_we;
      mem_dat_in = r1_wdat;
    end
  end

  // The count restarts when the grant goes to someone other than the current owner.
  always_comb begin : next_state
    state_nxt    = IDLE;
    last_nxt     = last;
    lock_cnt_nxt = 4'd0;
    sel_lock     = gnt0 ? r0_lock : r1_lock;
    other_req    = gnt0 ? r1_req : r0_req;
    base_cnt     = ((gnt0 && state == OWN0) || (gnt1 && state == OWN1)) ? lock_cnt : 4'd0;
    cnt_inc      = {1'b0, base_cnt} + 5'd1;
    if (gnt0 || gnt1) begin
      if (sel_lock && ((cnt_inc < LOCK_LIM) || !other_req)) begin
        state_nxt    = gnt0 ? OWN0 : OWN1;
        lock_cnt_nxt = cnt_inc[4] ? 4'hF : cnt_inc[3:0];
      end else begin
        last_nxt = gnt1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      last     <= 1'b1;
      lock_cnt <= 4'd0;
      rvld0_q  <= 1'b0;
      rvld1_q  <= 1'b0;
      r0_rdat  <= '0;
      r1_rdat  <= '0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      lock_cnt <= lock_cnt_nxt;
      rvld0_q  <= gnt0 && !r0_we;
      rvld1_q  <= gnt1 && !r1_we;
      if (gnt0 && !r0_we) r0_rdat <= mem_dat_out;
      if (gnt1 && !r1_we) r1_rdat <= mem_dat_out;
    end
  end

  // A read returning while reset is asserted is discarded.
  assign r0_rvld = rvld0_q && !reset;
  assign r1_rvld = rvld1_q && !reset;
  assign r0_gnt  = gnt0;
  assign r1_gnt  = gnt1;

endmodule
